// File: rtl/pad_ring_ctrl.sv
// Pad-ring controller: per-pad software registers, input synchronisers and a
// power-up sequencer that enables the ring one side at a time.
module pad_ring_ctrl #(
    parameter int unsigned     NSIDES  = 4,
    parameter int unsigned     NPADS   = 9,
    parameter int unsigned     CFGW    = 16,
    parameter logic [CFGW-1:0] CFG_RST = '0,
    parameter int unsigned     SEQ_DLY = 16,
    parameter int unsigned     NP      = NSIDES * NPADS,
    parameter int unsigned     AW      = $clog2(NP + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [AW-1:0]      req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    input  logic [NP-1:0]      core_dout,
    input  logic [NP-1:0]      core_oe,
    output logic [NP-1:0]      core_din,
    input  logic [NP-1:0]      pad_din,
    output logic [NP-1:0]      pad_dout,
    output logic [NP-1:0]      pad_ie,
    output logic [NP-1:0]      pad_oen,
    output logic [NP*CFGW-1:0] pad_tech_cfg
);

    localparam int unsigned CW = (SEQ_DLY > 1) ? $clog2(SEQ_DLY) : 1;
    localparam int unsigned SW = (NSIDES > 1) ? $clog2(NSIDES) : 1;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_EN,
        ST_DONE
    } seq_state_e;

    // Register file
    logic [CFGW-1:0] cfg_q [NP];
    logic [CFGW-1:0] cfg_d [NP];
    logic [NP-1:0]   ie_en_q, ie_en_d;
    logic [NP-1:0]   oe_en_q, oe_en_d;
    logic [NP-1:0]   force_en_q, force_en_d;
    logic [NP-1:0]   force_val_q, force_val_d;

    // Sequencer
    seq_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   side_idx_q, side_idx_d;
    logic [NSIDES-1:0] side_en_q, side_en_d;

    // Response channel
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;

    // Pad-facing outputs and input synchroniser
    logic [NP-1:0]      pad_dout_q, pad_dout_d;
    logic [NP-1:0]      pad_ie_q, pad_ie_d;
    logic [NP-1:0]      pad_oen_q, pad_oen_d;
    logic [NP*CFGW-1:0] pad_tech_cfg_q, pad_tech_cfg_d;
    logic [NP-1:0]      sync1_q, sync1_d;
    logic [NP-1:0]      sync2_q, sync2_d;

    logic        accept;
    logic        addr_err;
    logic [31:0] addr_ext;
    logic [31:0] rd_val;
    logic        unused_wdata;

    assign unused_wdata = ^req_wdata;

    assign req_ready    = ~rst;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign pad_dout     = pad_dout_q;
    assign pad_ie       = pad_ie_q;
    assign pad_oen      = pad_oen_q;
    assign pad_tech_cfg = pad_tech_cfg_q;
    assign core_din     = sync2_q & pad_ie_q;

    // Register access: reads sample pre-edge state so a write is visible to
    // a read accepted on the following cycle.
    always_comb begin
        accept      = req_valid & ~rst;
        addr_ext    = 32'(req_addr);
        addr_err    = (addr_ext > NP);
        rd_val      = '0;
        cfg_d       = cfg_q;
        ie_en_d     = ie_en_q;
        oe_en_d     = oe_en_q;
        force_en_d  = force_en_q;
        force_val_d = force_val_q;

        for (int unsigned p = 0; p < NP; p++) begin
            if (addr_ext == p) begin
                rd_val[CFGW-1:0] = cfg_q[p];
                rd_val[16]       = ie_en_q[p];
                rd_val[17]       = oe_en_q[p];
                rd_val[18]       = force_en_q[p];
                rd_val[19]       = force_val_q[p];
                if (accept && req_write) begin
                    cfg_d[p]       = req_wdata[CFGW-1:0];
                    ie_en_d[p]     = req_wdata[16];
                    oe_en_d[p]     = req_wdata[17];
                    force_en_d[p]  = req_wdata[18];
                    force_val_d[p] = req_wdata[19];
                end
            end
        end

        if (addr_ext == NP) begin
            rd_val[NSIDES-1:0] = side_en_q;
            rd_val[31]         = (state_q == ST_DONE);
        end

        rsp_valid_d = accept;
        rsp_err_d   = accept & addr_err;
        rsp_rdata_d = (accept && !req_write && !addr_err) ? rd_val : '0;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        side_idx_d = side_idx_q;
        side_en_d  = side_en_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(SEQ_DLY - 1)) begin
                    state_d = ST_EN;
                end
            end
            ST_EN: begin
                side_en_d[side_idx_q] = 1'b1;
                if (side_idx_q == SW'(NSIDES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    side_idx_d = side_idx_q + 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    // Pad side is p / NPADS; a disabled side never drives and shows CFG_RST.
    always_comb begin
        sync1_d        = pad_din;
        sync2_d        = sync1_q;
        pad_oen_d      = '1;
        pad_dout_d     = '0;
        pad_ie_d       = '0;
        pad_tech_cfg_d = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            pad_oen_d[p]  = ~(side_en_q[p / NPADS] & oe_en_q[p] &
                              (force_en_q[p] | core_oe[p]));
            pad_dout_d[p] = side_en_q[p / NPADS] & oe_en_q[p] &
                            (force_en_q[p] ? force_val_q[p] : core_dout[p]);
            pad_ie_d[p]   = side_en_q[p / NPADS] & ie_en_q[p];
            pad_tech_cfg_d[p*CFGW +: CFGW] = side_en_q[p / NPADS] ? cfg_q[p] : CFG_RST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_WAIT;
            cnt_q          <= '0;
            side_idx_q     <= '0;
            side_en_q      <= '0;
            for (int unsigned p = 0; p < NP; p++) begin
                cfg_q[p] <= CFG_RST;
            end
            ie_en_q        <= '0;
            oe_en_q        <= '0;
            force_en_q     <= '0;
            force_val_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_rdata_q    <= '0;
            pad_dout_q     <= '0;
            pad_ie_q       <= '0;
            pad_oen_q      <= '1;
            pad_tech_cfg_q <= {NP{CFG_RST}};
            sync1_q        <= '0;
            sync2_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            side_idx_q     <= side_idx_d;
            side_en_q      <= side_en_d;
            cfg_q          <= cfg_d;
            ie_en_q        <= ie_en_d;
            oe_en_q        <= oe_en_d;
            force_en_q     <= force_en_d;
            force_val_q    <= force_val_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_err_q      <= rsp_err_d;
            rsp_rdata_q    <= rsp_rdata_d;
            pad_dout_q     <= pad_dout_d;
            pad_ie_q       <= pad_ie_d;
            pad_oen_q      <= pad_oen_d;
            pad_tech_cfg_q <= pad_tech_cfg_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
        end
    end

endmodule

// File: tb/tb_pad_ring_ctrl.sv
// Directed bench for pad_ring_ctrl: reset, side sequencing, register/pad
// behaviour, input synchroniser and mid-sequence reset.
module tb_pad_ring_ctrl;

    localparam int          NSIDES  = 4;
    localparam int          NPADS   = 9;
    localparam int          CFGW    = 16;
    localparam int          SEQ_DLY = 16;
    localparam int          NP      = NSIDES * NPADS;
    localparam int          AW      = $clog2(NP + 1);
    localparam logic [15:0] CFG_RST = 16'h0000;
    localparam int          STEP    = SEQ_DLY + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [AW-1:0]      req_addr;
    logic [31:0]        req_wdata;
    logic               rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic [NP-1:0]      core_dout;
    logic [NP-1:0]      core_oe;
    logic [NP-1:0]      core_din;
    logic [NP-1:0]      pad_din;
    logic [NP-1:0]      pad_dout;
    logic [NP-1:0]      pad_ie;
    logic [NP-1:0]      pad_oen;
    logic [NP*CFGW-1:0] pad_tech_cfg;

    int checks = 0;
    int errors = 0;

    pad_ring_ctrl #(
        .NSIDES (NSIDES),
        .NPADS  (NPADS),
        .CFGW   (CFGW),
        .CFG_RST(CFG_RST),
        .SEQ_DLY(SEQ_DLY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .core_dout   (core_dout),
        .core_oe     (core_oe),
        .core_din    (core_din),
        .pad_din     (pad_din),
        .pad_dout    (pad_dout),
        .pad_ie      (pad_ie),
        .pad_oen     (pad_oen),
        .pad_tech_cfg(pad_tech_cfg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        wr;
        int          addr;
        logic [31:0] wdata;
        logic        c_oe0;
        logic        c_dout0;
        logic        e_valid;
        logic        e_err;
        logic [31:0] e_rdata;
        logic        e_oen0;
        logic        e_dout0;
        logic [15:0] e_cfg0;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input int a, input logic [31:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = AW'(a);
        req_wdata = d;
    endtask

    function automatic logic [31:0] exp_status(input int n);
        logic [31:0] m;
        m = '0;
        for (int j = 0; j < NSIDES; j++) begin
            if ((j + 1) * STEP <= n) m[j] = 1'b1;
        end
        if (n >= NSIDES * STEP) m[31] = 1'b1;
        return m;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_oen_all1"}, 32'(pad_oen == '1), 32'd1);
        chk({tag, "_dout0"}, 32'(pad_dout == '0), 32'd1);
        chk({tag, "_ie0"}, 32'(pad_ie == '0), 32'd1);
        chk({tag, "_core_din0"}, 32'(core_din == '0), 32'd1);
        chk({tag, "_cfg_rst"}, 32'(pad_tech_cfg == {NP{CFG_RST}}), 32'd1);
    endtask

    initial begin
        //              valid wr    addr    wdata          oe0   dout0 e_val e_err e_rdata        oen0  dout0 cfg0
        vecs[0]  = '{1'b1, 1'b1, 0,      32'h000E_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 16'h0};
        vecs[1]  = '{1'b1, 1'b0, 0,      32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h000E_0000, 1'b0, 1'b1, 16'h0};
        vecs[2]  = '{1'b1, 1'b1, 0,      32'h0002_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 16'h0};
        vecs[3]  = '{1'b0, 1'b0, 0,      32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 16'h0};
        vecs[4]  = '{1'b1, 1'b0, 0,      32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0002_0000, 1'b0, 1'b0, 16'h0};
        vecs[5]  = '{1'b1, 1'b0, 10,     32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0003_00A5, 1'b0, 1'b1, 16'h0};
        vecs[6]  = '{1'b1, 1'b0, NP + 1, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 16'h0};
        vecs[7]  = '{1'b1, 1'b1, NP + 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 16'h0};
        vecs[8]  = '{1'b1, 1'b0, NP,     32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_000F, 1'b1, 1'b0, 16'h0};
        vecs[9]  = '{1'b1, 1'b1, NP,     32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 16'h0};
        vecs[10] = '{1'b1, 1'b0, NP,     32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_000F, 1'b1, 1'b0, 16'h0};
        vecs[11] = '{1'b1, 1'b1, 63,     32'h000F_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 16'h0};
        vecs[12] = '{1'b1, 1'b0, NP - 1, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 16'h0};
        vecs[13] = '{1'b1, 1'b1, 0,      32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 16'h0};
        vecs[14] = '{1'b1, 1'b0, 0,      32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h000F_FFFF, 1'b0, 1'b1, 16'hFFFF};
        vecs[15] = '{1'b1, 1'b1, 0,      32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 16'hFFFF};
        vecs[16] = '{1'b0, 1'b0, 0,      32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 16'h0};

        rst       = 1'b1;
        core_dout = '0;
        core_oe   = '0;
        core_oe[10]   = 1'b1;
        core_dout[10] = 1'b1;
        pad_din   = '0;
        drive(1'b0, 1'b0, 0, 32'h0);

        // Reset held five cycles
        for (int i = 0; i < 5; i++) step();
        chk_reset_outputs("reset");

        // Release and read status every cycle; write pad 10 before side 1 is up
        rst = 1'b0;
        for (int k = 1; k <= 75; k++) begin
            if (k == 20) drive(1'b1, 1'b1, 10, 32'h0003_00A5);
            else         drive(1'b1, 1'b0, NP, 32'h0);
            step();
            chk("seq_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("seq_rsp_err", 32'(rsp_err), 32'd0);
            if (k != 20) chk($sformatf("status_k%0d", k), rsp_rdata, exp_status(k - 1));
            chk($sformatf("cfg10_k%0d", k), 32'(pad_tech_cfg[10*CFGW +: CFGW]),
                (k - 1 >= 2 * STEP) ? 32'h00A5 : 32'(CFG_RST));
            chk($sformatf("oen10_k%0d", k), 32'(pad_oen[10]), (k - 1 >= 2 * STEP) ? 32'd0 : 32'd1);
            chk($sformatf("dout10_k%0d", k), 32'(pad_dout[10]), (k - 1 >= 2 * STEP) ? 32'd1 : 32'd0);
            chk("oen_others", 32'((pad_oen | (NP'(1) << 10)) == '1), 32'd1);
        end

        // Table-driven register / force-mode vectors (all sides enabled)
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].valid, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            core_oe[0]   = vecs[i].c_oe0;
            core_dout[0] = vecs[i].c_dout0;
            step();
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].e_err));
            if (!(vecs[i].wr && vecs[i].valid && !vecs[i].e_err))
                chk($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].e_rdata);
            chk($sformatf("v%0d_oen0", i), 32'(pad_oen[0]), 32'(vecs[i].e_oen0));
            chk($sformatf("v%0d_dout0", i), 32'(pad_dout[0]), 32'(vecs[i].e_dout0));
            chk($sformatf("v%0d_cfg0", i), 32'(pad_tech_cfg[CFGW-1:0]), 32'(vecs[i].e_cfg0));
        end

        // Input synchroniser on pad 3 with ie_en set
        drive(1'b1, 1'b1, 3, 32'h0001_0000);
        step();
        drive(1'b0, 1'b0, 0, 32'h0);
        step();
        step();
        chk("pad_ie3_on", 32'(pad_ie[3]), 32'd1);
        pad_din[3] = 1'b1;
        step();
        chk("din_rise_1cyc", 32'(core_din[3]), 32'd0);
        step();
        chk("din_rise_2cyc", 32'(core_din[3]), 32'd1);
        pad_din[3] = 1'b0;
        step();
        chk("din_fall_1cyc", 32'(core_din[3]), 32'd1);
        step();
        chk("din_fall_2cyc", 32'(core_din[3]), 32'd0);

        // ie_en cleared: input masked
        drive(1'b1, 1'b1, 3, 32'h0);
        step();
        drive(1'b0, 1'b0, 0, 32'h0);
        step();
        step();
        chk("pad_ie3_off", 32'(pad_ie[3]), 32'd0);
        pad_din[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("din_masked_%0d", i), 32'(core_din[3]), 32'd0);
        end
        pad_din[3] = 1'b0;

        // Restart the sequence, then reset at cycle 40
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int k = 1; k <= 39; k++) begin
            if (k == 2) drive(1'b1, 1'b1, 10, 32'h0003_00A5);
            else        drive(1'b1, 1'b0, NP, 32'h0);
            step();
            if (k != 2) chk($sformatf("rs_status_k%0d", k), rsp_rdata, exp_status(k - 1));
        end
        chk("pre_rst_oen10", 32'(pad_oen[10]), 32'd0);
        chk("pre_rst_ie10", 32'(pad_ie[10]), 32'd1);
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        step();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 1'b0, NP, 32'h0);
            step();
            chk($sformatf("re_status_k%0d", k), rsp_rdata, exp_status(k - 1));
        end
        drive(1'b1, 1'b0, 10, 32'h0);
        step();
        chk("pad10_after_rst", rsp_rdata, 32'h0);
        chk("cfg10_after_rst", 32'(pad_tech_cfg[10*CFGW +: CFGW]), 32'(CFG_RST));
        drive(1'b0, 1'b0, 0, 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
